// File: rtl/burst_ram_arbiter.sv
// rtl/burst_ram_arbiter.sv - round-robin arbiter sharing one BurstRAM port between two burst masters
module burst_ram_arbiter #(
  parameter int RAM_DEPTH_BITWIDTH      = 8,
  parameter int RAM_BURST_DATA_BITWIDTH = 64,
  parameter int RAM_BURST_DATA_COUNT    = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  // requester 0: instruction cache
  input  logic                                 m0_req,
  output logic                                 m0_gnt,
  input  logic                                 m0_cmd,
  input  logic                                 m0_cmd_en,
  input  logic [RAM_DEPTH_BITWIDTH-1:0]        m0_addr,
  input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   m0_wr_data,
  input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0] m0_data_mask,
  output logic [RAM_BURST_DATA_BITWIDTH-1:0]   m0_rd_data,
  output logic                                 m0_rd_data_valid,
  // requester 1: data cache
  input  logic                                 m1_req,
  output logic                                 m1_gnt,
  input  logic                                 m1_cmd,
  input  logic                                 m1_cmd_en,
  input  logic [RAM_DEPTH_BITWIDTH-1:0]        m1_addr,
  input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   m1_wr_data,
  input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0] m1_data_mask,
  output logic [RAM_BURST_DATA_BITWIDTH-1:0]   m1_rd_data,
  output logic                                 m1_rd_data_valid,
  // BurstRAM port
  output logic                                 br_cmd,
  output logic                                 br_cmd_en,
  output logic [RAM_DEPTH_BITWIDTH-1:0]        br_addr,
  output logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_wr_data,
  output logic [RAM_BURST_DATA_BITWIDTH/8-1:0] br_data_mask,
  input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_rd_data,
  input  logic                                 br_rd_data_valid,
  input  logic                                 br_busy,
  output logic                                 busy
);

  localparam int CW = $clog2(RAM_BURST_DATA_COUNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(RAM_BURST_DATA_COUNT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] GRANTED     = 3'd1;
  localparam logic [2:0] WRITE_BEATS = 3'd2;
  localparam logic [2:0] READ_WAIT   = 3'd3;
  localparam logic [2:0] READ_BEATS  = 3'd4;

  logic [2:0]    state;
  logic          owner;
  logic          last_owner;
  logic [CW-1:0] cnt;

  logic                                 own_req;
  logic                                 own_cmd;
  logic                                 own_cmd_en;
  logic [RAM_DEPTH_BITWIDTH-1:0]        own_addr;
  logic [RAM_BURST_DATA_BITWIDTH-1:0]   own_wr_data;
  logic [RAM_BURST_DATA_BITWIDTH/8-1:0] own_data_mask;
  logic                                 has_owner;
  logic                                 win;
  logic                                 done;

  // Select the current owner's request-side signals
  always_comb begin
    own_req       = owner ? m1_req       : m0_req;
    own_cmd       = owner ? m1_cmd       : m0_cmd;
    own_cmd_en    = owner ? m1_cmd_en    : m0_cmd_en;
    own_addr      = owner ? m1_addr      : m0_addr;
    own_wr_data   = owner ? m1_wr_data   : m0_wr_data;
    own_data_mask = owner ? m1_data_mask : m0_data_mask;
  end

  // Round-robin pick: on a tie the requester that did not own the port last wins
  always_comb begin
    win = 1'b0;
    if (m0_req && m1_req) win = ~last_owner;
    else if (m1_req)      win = 1'b1;
  end

  // Burst-complete / abandon condition that hands the port back
  always_comb begin
    done = 1'b0;
    case (state)
      GRANTED:     done = !own_cmd_en && !own_req;
      WRITE_BEATS: done = (cnt == CNT_LAST);
      READ_BEATS:  done = br_rd_data_valid && (cnt == CNT_LAST);
      default:     done = 1'b0;
    endcase
  end

  assign has_owner = (state != IDLE);
  assign busy      = has_owner;

  // The br_ bus is quiet when nobody owns it; cmd_en only passes before a command is taken
  assign br_cmd_en    = (state == GRANTED) && own_cmd_en;
  assign br_cmd       = has_owner ? own_cmd       : 1'b0;
  assign br_addr      = has_owner ? own_addr      : '0;
  assign br_wr_data   = has_owner ? own_wr_data   : '0;
  assign br_data_mask = has_owner ? own_data_mask : '0;

  assign m0_rd_data       = br_rd_data;
  assign m1_rd_data       = br_rd_data;
  assign m0_rd_data_valid = br_rd_data_valid && has_owner && !owner;
  assign m1_rd_data_valid = br_rd_data_valid && has_owner &&  owner;

  // Ownership state machine and beat counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      cnt        <= '0;
      m0_gnt     <= 1'b0;
      m1_gnt     <= 1'b0;
    end else if (done) begin
      state      <= IDLE;
      last_owner <= owner;
      cnt        <= '0;
      m0_gnt     <= 1'b0;
      m1_gnt     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!br_busy && (m0_req || m1_req)) begin
            state  <= GRANTED;
            owner  <= win;
            m0_gnt <= !win;
            m1_gnt <= win;
            cnt    <= '0;
          end
        end
        GRANTED: begin
          if (own_cmd_en) begin
            // First write beat leaves with the command itself
            state <= own_cmd ? WRITE_BEATS : READ_WAIT;
            cnt   <= own_cmd ? CNT_ONE : '0;
          end
        end
        WRITE_BEATS: cnt <= cnt + CNT_ONE;
        READ_WAIT: begin
          if (br_rd_data_valid) begin
            state <= READ_BEATS;
            cnt   <= CNT_ONE;
          end
        end
        READ_BEATS: begin
          if (br_rd_data_valid) cnt <= cnt + CNT_ONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// tb/tb_burst_ram_arbiter.sv - self-checking bench for burst_ram_arbiter
module tb_burst_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_gnt, m0_cmd, m0_cmd_en, m0_rd_data_valid;
  logic [7:0]  m0_addr, m0_data_mask;
  logic [63:0] m0_wr_data, m0_rd_data;
  logic        m1_req, m1_gnt, m1_cmd, m1_cmd_en, m1_rd_data_valid;
  logic [7:0]  m1_addr, m1_data_mask;
  logic [63:0] m1_wr_data, m1_rd_data;
  logic        br_cmd, br_cmd_en, br_rd_data_valid, br_busy, busy;
  logic [7:0]  br_addr, br_data_mask;
  logic [63:0] br_wr_data, br_rd_data;

  int tests_run = 0;
  int tests_failed = 0;
  logic [63:0] rdq0[$];
  logic [63:0] rdq1[$];
  logic [63:0] wbeats[4];

  always #5 clk = ~clk;

  burst_ram_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_gnt(m0_gnt), .m0_cmd(m0_cmd), .m0_cmd_en(m0_cmd_en),
    .m0_addr(m0_addr), .m0_wr_data(m0_wr_data), .m0_data_mask(m0_data_mask),
    .m0_rd_data(m0_rd_data), .m0_rd_data_valid(m0_rd_data_valid),
    .m1_req(m1_req), .m1_gnt(m1_gnt), .m1_cmd(m1_cmd), .m1_cmd_en(m1_cmd_en),
    .m1_addr(m1_addr), .m1_wr_data(m1_wr_data), .m1_data_mask(m1_data_mask),
    .m1_rd_data(m1_rd_data), .m1_rd_data_valid(m1_rd_data_valid),
    .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr),
    .br_wr_data(br_wr_data), .br_data_mask(br_data_mask),
    .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid),
    .br_busy(br_busy), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Drive n consecutive read beats to requester 0, queuing the data it should see
  task automatic read_beats_m0(input int n, input logic [63:0] base, input bit busy_mid);
    for (int i = 0; i < n; i++) begin
      br_rd_data       = base + 64'(i);
      br_rd_data_valid = 1'b1;
      br_busy          = busy_mid && (i == 1 || i == 2);
      rdq0.push_back(base + 64'(i));
      settle();
      check("beat_gnt0", {63'd0, m0_gnt}, 64'd1);
      cyc();
    end
    br_rd_data_valid = 1'b0;
    br_busy          = 1'b0;
  endtask

  // Scoreboard: every valid beat seen by a requester must match the queued data
  always @(negedge clk) begin
    if (m0_rd_data_valid) begin
      if (rdq0.size() == 0) check("m0_unexpected_valid", 64'd1, 64'd0);
      else check("m0_rd_data", m0_rd_data, rdq0.pop_front());
    end
    if (m1_rd_data_valid) begin
      if (rdq1.size() == 0) check("m1_unexpected_valid", 64'd1, 64'd0);
      else check("m1_rd_data", m1_rd_data, rdq1.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    wbeats[0] = 64'h11; wbeats[1] = 64'h22; wbeats[2] = 64'h33; wbeats[3] = 64'h44;
    rst = 1'b1;
    m0_req = 0; m0_cmd = 0; m0_cmd_en = 0; m0_addr = 0; m0_wr_data = 0; m0_data_mask = 0;
    m1_req = 0; m1_cmd = 0; m1_cmd_en = 0; m1_addr = 0; m1_wr_data = 0; m1_data_mask = 0;
    br_rd_data = 0; br_rd_data_valid = 0; br_busy = 0;
    repeat (3) cyc();
    m0_addr = 8'h5A; m0_wr_data = 64'hDEAD; m0_data_mask = 8'h0F;
    settle();
    check("rst_gnt0", {63'd0, m0_gnt}, 64'd0);
    check("rst_gnt1", {63'd0, m1_gnt}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_cmd_en", {63'd0, br_cmd_en}, 64'd0);
    check("rst_addr", {56'd0, br_addr}, 64'd0);
    check("rst_wr_data", br_wr_data, 64'd0);
    check("rst_mask", {56'd0, br_data_mask}, 64'd0);
    rst = 1'b0;
    m0_addr = 0; m0_wr_data = 0; m0_data_mask = 0;
    cyc();

    // m0 read burst
    m0_req = 1'b1;
    settle();
    check("t1_gnt_before_edge", {63'd0, m0_gnt}, 64'd0);
    cyc(); settle();
    check("t1_gnt0", {63'd0, m0_gnt}, 64'd1);
    check("t1_gnt1", {63'd0, m1_gnt}, 64'd0);
    check("t1_busy", {63'd0, busy}, 64'd1);
    m0_cmd_en = 1'b1; m0_cmd = 1'b0; m0_addr = 8'h12; m0_req = 1'b0;
    settle();
    check("t1_br_cmd_en", {63'd0, br_cmd_en}, 64'd1);
    check("t1_br_addr", {56'd0, br_addr}, 64'h12);
    check("t1_br_cmd", {63'd0, br_cmd}, 64'd0);
    cyc();
    m0_cmd_en = 1'b0;
    settle();
    check("t1_cmd_en_one_cycle", {63'd0, br_cmd_en}, 64'd0);
    cyc();
    m0_cmd_en = 1'b1;
    settle();
    check("t1_second_cmd_en", {63'd0, br_cmd_en}, 64'd0);
    cyc();
    m0_cmd_en = 1'b0;
    read_beats_m0(4, 64'hA, 1'b1);
    settle();
    check("t1_release_gnt0", {63'd0, m0_gnt}, 64'd0);
    check("t1_release_busy", {63'd0, busy}, 64'd0);

    // m1 write burst
    m1_req = 1'b1;
    cyc(); settle();
    check("t2_gnt1", {63'd0, m1_gnt}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      m1_cmd_en = (i == 0); m1_cmd = 1'b1; m1_addr = 8'h40; m1_data_mask = 8'hFF;
      m1_wr_data = wbeats[i]; m1_req = 1'b0;
      settle();
      check("t2_wr_data", br_wr_data, wbeats[i]);
      check("t2_cmd_en", {63'd0, br_cmd_en}, (i == 0) ? 64'd1 : 64'd0);
      check("t2_mask", {56'd0, br_data_mask}, 64'hFF);
      check("t2_gnt1_held", {63'd0, m1_gnt}, 64'd1);
      cyc();
    end
    m1_cmd_en = 1'b0;
    settle();
    check("t2_release_gnt1", {63'd0, m1_gnt}, 64'd0);
    check("t2_release_busy", {63'd0, busy}, 64'd0);
    check("t2_idle_wr_data", br_wr_data, 64'd0);

    // tie after reset, alternation, repeated tie
    rst = 1'b1;
    cyc();
    rst = 1'b0; m0_req = 1'b1; m1_req = 1'b1;
    cyc(); settle();
    check("t3_tie_gnt0", {63'd0, m0_gnt}, 64'd1);
    check("t3_tie_gnt1", {63'd0, m1_gnt}, 64'd0);
    m0_cmd_en = 1'b1; m0_cmd = 1'b0; m0_addr = 8'h20; m0_req = 1'b0;
    cyc();
    m0_cmd_en = 1'b0;
    read_beats_m0(4, 64'h100, 1'b0);
    settle();
    check("t3_gap_gnt0", {63'd0, m0_gnt}, 64'd0);
    check("t3_gap_gnt1", {63'd0, m1_gnt}, 64'd0);
    cyc(); settle();
    check("t3_m1_next", {63'd0, m1_gnt}, 64'd1);
    m1_cmd_en = 1'b1; m1_cmd = 1'b1; m1_req = 1'b0; m0_req = 1'b1;
    cyc();
    m1_cmd_en = 1'b0;
    cyc(); cyc();
    m1_req = 1'b1;
    cyc(); settle();
    check("t3_m1_release", {63'd0, m1_gnt}, 64'd0);
    cyc(); settle();
    check("t3_tie2_gnt0", {63'd0, m0_gnt}, 64'd1);
    check("t3_tie2_gnt1", {63'd0, m1_gnt}, 64'd0);

    // non-owner cmd_en ignored, owner abandons
    m1_req = 1'b0; m1_cmd_en = 1'b1; m1_cmd = 1'b1;
    settle();
    check("t4_nonowner_cmd_en", {63'd0, br_cmd_en}, 64'd0);
    check("t4_nonowner_cmd", {63'd0, br_cmd}, 64'd0);
    cyc();
    m1_cmd_en = 1'b0;
    settle();
    check("t4_still_gnt0", {63'd0, m0_gnt}, 64'd1);
    check("t4_still_busy", {63'd0, busy}, 64'd1);
    m0_req = 1'b0;
    settle();
    check("t4_abandon_cmd_en", {63'd0, br_cmd_en}, 64'd0);
    cyc(); settle();
    check("t4_abandon_gnt0", {63'd0, m0_gnt}, 64'd0);
    check("t4_abandon_busy", {63'd0, busy}, 64'd0);

    // br_busy holds off the grant
    br_busy = 1'b1; m0_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(); settle();
      check("t5_busy_hold", {63'd0, m0_gnt}, 64'd0);
    end
    br_busy = 1'b0;
    cyc(); settle();
    check("t5_gnt_after_busy", {63'd0, m0_gnt}, 64'd1);

    // async reset in the middle of a read burst
    m0_cmd_en = 1'b1; m0_cmd = 1'b0; m0_addr = 8'h30; m0_req = 1'b0;
    cyc();
    m0_cmd_en = 1'b0;
    read_beats_m0(2, 64'h200, 1'b0);
    rst = 1'b1;
    #1;
    check("t6_rst_gnt0", {63'd0, m0_gnt}, 64'd0);
    check("t6_rst_busy", {63'd0, busy}, 64'd0);
    check("t6_rst_cmd_en", {63'd0, br_cmd_en}, 64'd0);
    check("t6_rst_addr", {56'd0, br_addr}, 64'd0);
    cyc();
    rst = 1'b0; m1_req = 1'b1;
    cyc(); settle();
    check("t6_m1_gnt", {63'd0, m1_gnt}, 64'd1);
    check("t6_m0_gnt", {63'd0, m0_gnt}, 64'd0);
    m1_req = 1'b0;
    cyc(); settle();
    check("t6_m1_release", {63'd0, m1_gnt}, 64'd0);
    check("rdq0_drained", 64'(rdq0.size()), 64'd0);
    check("rdq1_drained", 64'(rdq1.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
